// File: rtl/alu_multu_seq.sv
// Sequencer for unsigned MULTU: runs shift-add multiplication on the external
// ALU array by issuing one ADD per iteration and accumulating into HI/LO.
module alu_multu_seq #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       signal,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic [5:0]       alu_signal,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_sum,
   input  logic             alu_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_NOP   = 6'b000000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] hi_r;
   logic [WIDTH-1:0] lo_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [5:0]       alu_signal_r;
   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;

   logic [WIDTH-1:0] hi_nxt_s;
   logic [WIDTH-1:0] lo_nxt_s;
   logic             last_s;

   // Next partial product: take the ALU sum (with its carry) when the multiplier LSB is set.
   always_comb begin
      hi_nxt_s = hi_r;
      lo_nxt_s = lo_r;
      last_s   = (cnt_r == CNT_LAST);
      if (lo_r[0]) begin
         {hi_nxt_s, lo_nxt_s} = {alu_cout, alu_sum, lo_r[WIDTH-1:1]};
      end else begin
         {hi_nxt_s, lo_nxt_s} = {1'b0, hi_r, lo_r[WIDTH-1:1]};
      end
   end

   // Control FSM with registered handshake and ALU drive; alu_a tracks hi while in RUN.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         m_r          <= '0;
         hi_r         <= '0;
         lo_r         <= '0;
         cnt_r        <= '0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         alu_signal_r <= FN_NOP;
         alu_a_r      <= '0;
         alu_b_r      <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start && (signal == FN_MULTU)) begin
                  state_r      <= ST_RUN;
                  m_r          <= dataA;
                  hi_r         <= '0;
                  lo_r         <= dataB;
                  cnt_r        <= '0;
                  busy_r       <= 1'b1;
                  alu_signal_r <= FN_ADD;
                  alu_a_r      <= '0;
                  alu_b_r      <= dataA;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_RUN: begin
               hi_r  <= hi_nxt_s;
               lo_r  <= lo_nxt_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (last_s) begin
                  state_r      <= ST_DONE;
                  busy_r       <= 1'b0;
                  done_r       <= 1'b1;
                  alu_signal_r <= FN_NOP;
                  alu_a_r      <= '0;
                  alu_b_r      <= '0;
               end else begin
                  alu_a_r <= hi_nxt_s;
                  alu_b_r <= m_r;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r      <= ST_IDLE;
               busy_r       <= 1'b0;
               done_r       <= 1'b0;
               alu_signal_r <= FN_NOP;
               alu_a_r      <= '0;
               alu_b_r      <= '0;
            end
         endcase
      end
   end

   assign alu_signal = alu_signal_r;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign hi         = hi_r;
   assign lo         = lo_r;

endmodule

// File: tb/tb_alu_multu_seq.sv
// Bench for alu_multu_seq: behavioural ALU array plus a plain 64-bit product
// reference, with directed and randomized multiplications.
module tb_alu_multu_seq;

   localparam logic [5:0] MULTU = 6'b011001;
   localparam logic [5:0] ADD   = 6'b100000;
   localparam logic [5:0] SUB   = 6'b100010;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  signal;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic [5:0]  alu_signal;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_sum;
   logic        alu_cout;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_p = 64'd0;
   logic [32:0] alu_res_s;

   always #5 clk = ~clk;

   // Behavioural ALU array: 32-bit add/sub with carry-out, zero otherwise.
   always_comb begin
      alu_res_s = 33'd0;
      if (alu_signal == ADD) begin
         alu_res_s = {1'b0, alu_a} + {1'b0, alu_b};
      end else if (alu_signal == SUB) begin
         alu_res_s = {1'b0, alu_a} - {1'b0, alu_b};
      end else begin
         alu_res_s = 33'd0;
      end
   end
   assign alu_sum  = alu_res_s[31:0];
   assign alu_cout = alu_res_s[32];

   alu_multu_seq dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .signal     (signal),
      .dataA      (dataA),
      .dataB      (dataB),
      .alu_signal (alu_signal),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_sum    (alu_sum),
      .alu_cout   (alu_cout),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One MULTU from accept to done pulse; optionally re-requests 7x9 mid-run and holds start.
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit inject);
      logic [63:0] exp_p;
      int n;
      int busy_n;
      exp_p  = {32'd0, a} * {32'd0, b};
      start  = 1'b1;
      signal = MULTU;
      dataA  = a;
      dataB  = b;
      step();
      if (!inject) start = 1'b0;
      dataA  = $urandom;
      dataB  = $urandom;
      n      = 1;
      busy_n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) begin
            busy_n++;
            chk("alu_signal_run", {58'd0, alu_signal}, {58'd0, ADD});
            chk("alu_b_run", {32'd0, alu_b}, {32'd0, a});
         end
         if (inject && n == 5) begin
            start  = 1'b1;
            signal = MULTU;
            dataA  = 32'd7;
            dataB  = 32'd9;
         end
         step();
         n++;
      end
      chk("latency", 64'(n), 64'd33);
      chk("busy_cycles", 64'(busy_n), 64'd32);
      chk("busy_in_done", {63'd0, busy}, 64'd0);
      chk("alu_signal_done", {58'd0, alu_signal}, 64'd0);
      chk("hi", {32'd0, hi}, {32'd0, exp_p[63:32]});
      chk("lo", {32'd0, lo}, {32'd0, exp_p[31:0]});
      last_p = exp_p;
   endtask

   // Edge leaving DONE: back in IDLE with the product held.
   task automatic leave_done();
      step();
      chk("done_pulse_width", {63'd0, done}, 64'd0);
      chk("busy_idle", {63'd0, busy}, 64'd0);
      chk("hold_p", {hi, lo}, last_p);
   endtask

   initial begin
      bit seen_done;
      reset  = 1'b0;
      start  = 1'b0;
      signal = 6'd0;
      dataA  = 32'd0;
      dataB  = 32'd0;
      step();
      step();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_p", {hi, lo}, 64'd0);
      chk("rst_alu_signal", {58'd0, alu_signal}, 64'd0);
      chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
      reset = 1'b1;
      step();

      run_mult(32'd3, 32'd5, 1'b0);
      chk("p_3x5", {hi, lo}, 64'h0000_0000_0000_000F);
      leave_done();
      run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("p_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      leave_done();
      run_mult(32'h1234_5678, 32'd0, 1'b0);
      leave_done();
      run_mult(32'd0, 32'h9ABC_DEF0, 1'b0);
      leave_done();
      run_mult(32'h8000_0001, 32'hC000_0003, 1'b0);
      leave_done();

      // Non-MULTU codes are ignored while idle.
      start  = 1'b1;
      signal = ADD;
      dataA  = 32'd11;
      dataB  = 32'd13;
      repeat (3) step();
      chk("add_busy", {62'd0, busy, done}, 64'd0);
      chk("add_hold", {hi, lo}, last_p);
      signal = SUB;
      repeat (3) step();
      chk("sub_busy", {62'd0, busy, done}, 64'd0);
      chk("sub_hold", {hi, lo}, last_p);
      start = 1'b0;
      step();

      // Start during RUN is dropped; held start is taken once IDLE.
      run_mult(32'h0001_0003, 32'h0000_0101, 1'b1);
      step();
      chk("idle_after_done_busy", {63'd0, busy}, 64'd0);
      chk("idle_after_done_done", {63'd0, done}, 64'd0);
      run_mult(32'd7, 32'd9, 1'b0);
      chk("lo_63", {32'd0, lo}, 64'd63);
      leave_done();

      // Reset mid-run discards the partial product.
      start  = 1'b1;
      signal = MULTU;
      dataA  = 32'h0000_FFFF;
      dataB  = 32'h0000_FFFF;
      step();
      start = 1'b0;
      repeat (10) step();
      chk("midrun_busy", {63'd0, busy}, 64'd1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rst_mid_busy", {63'd0, busy}, 64'd0);
      chk("rst_mid_done", {63'd0, done}, 64'd0);
      chk("rst_mid_p", {hi, lo}, 64'd0);
      chk("rst_mid_alu_signal", {58'd0, alu_signal}, 64'd0);
      seen_done = 1'b0;
      repeat (40) begin
         step();
         if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      end
      chk("rst_mid_no_done", {63'd0, seen_done}, 64'd0);
      last_p = 64'd0;
      run_mult(32'd2, 32'd2, 1'b0);
      chk("lo_4", {32'd0, lo}, 64'd4);
      leave_done();

      for (int i = 0; i < 8; i++) begin
         run_mult($urandom, $urandom, 1'b0);
         leave_done();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
